vc_input_request_unit: RTL and testbench
========================================

Name: vc_input_request_unit

Overview:
- Requestor-side counterpart of the router's wavefront switch allocator; one instance per router input port.
- Buffers routed flits and drives the one-hot output-port request row into the allocator.
- Consumes the allocator grant, pops the granted flit and launches it to the crossbar, tracking downstream credits per output port.

Parameters:
NUM_PORTS, 4, router ports; width of request/grant/destination vectors
FLIT_W, 32, flit payload width in bits
DEPTH, 4, input FIFO depth in flits (power of two, >=2)
CREDITS, 4, initial and maximum downstream credit count per output port

Ports:
clk  input  1  clock
reset  input  1  asynchronous active-high reset
in_valid  input  1  upstream flit valid
in_ready  output  1  FIFO can accept a flit this cycle
in_flit  input  FLIT_W  flit payload
in_dest  input  NUM_PORTS  one-hot routed output port of in_flit
req  output  NUM_PORTS  allocator request row; one-hot or zero
grant  input  NUM_PORTS  allocator grant bits for this input (same cycle as req)
out_valid  output  1  registered crossbar flit valid
out_flit  output  FLIT_W  registered crossbar payload
out_port  output  NUM_PORTS  registered one-hot crossbar select
credit_return  input  NUM_PORTS  per-port credit return pulse, one credit per bit per cycle
err  output  1  sticky protocol error flag

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - FIFO is empty; in_ready=1.
  - req=0, out_valid=0, out_flit=0, out_port=0.
  - All credit counters = CREDITS; err=0; state=IDLE.
- FIFO:
  - Push when in_valid&in_ready.
  - in_ready = !full, based on registered count only. There is no same-cycle push-through when full.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo DEPTH.
  - An in_dest that is not one-hot on push sets err. The flit is still stored, and its request is masked to zero forever (deadlock is visible to verification).
- Credit counters: width $clog2(CREDITS+1), one per port.
  - Decrement on accepted grant to that port.
  - Increment on credit_return bit.
  - Both in the same cycle: unchanged.
  - A return when the counter equals CREDITS sets err and the counter holds at CREDITS.
- State machine, evaluated on registered head state:
  - IDLE: FIFO empty. req=0. Go to REQ or BLOCKED on first push.
  - REQ: head valid and credit[head_dest]>0. req=head_dest.
  - BLOCKED: head valid and credit[head_dest]==0. req=0. Go to REQ the cycle after a credit return to head_dest.
- req is a pure function of registers; it never depends combinationally on grant (no loop through the allocator).
- Grant acceptance:
  - accept = |(grant & req).
  - On accept at the clk edge:
    - Pop the head.
    - Decrement credit[head_dest].
    - Register out_valid=1, out_flit=head, out_port=head_dest.
    - Next state is recomputed from the new head and credits.
  - Grant-to-output latency: 1 cycle. With no accept, out_valid=0 the next cycle.
  - Back-to-back: a new head may request the cycle after a pop. Throughput is 1 flit/cycle while granted and credited.
- Error cases:
  - grant & ~req nonzero (grant without request, or wrong port): set err, ignore those bits.
  - err clears only on reset.
- Reset mid-operation: all state clears immediately and asynchronously. An in-flight out_valid drops and buffered flits are discarded.

Optional Feature:
- Macro: VC_IRU_AGE_URGENT_EN
- Defined:
  - Adds parameter AGE_MAX (default 15) and output urgent (1 bit).
  - An age counter increments each cycle in REQ without accept and saturates at AGE_MAX.
  - The counter clears on accept, on leaving REQ, and on reset.
  - urgent=1 while age==AGE_MAX; the router uses it for allocator priority override.
- Undefined: no counter and no urgent port; behaviour is otherwise identical.

Test Plan:
- Reset, then push flit 0xA5A5A5A5 dest 0010, grant=0010 next cycle -> req=0010 one cycle after push; one cycle after grant out_valid=1, out_flit=0xA5A5A5A5, out_port=0010; FIFO empty, req=0.
- Push 4 flits with grant=0 -> in_ready=0 after the 4th; a 5th in_valid is not accepted; granting one raises in_ready the next cycle.
- 5 flits all dest 0001, continuous grant, no credit_return -> 4 flits out back-to-back; then state BLOCKED with req=0. One credit_return[0] -> req=0001 the next cycle; 5th flit out after grant.
- Same-cycle accept on port 1 and credit_return[1] -> credit[1] unchanged (4); credit_return[2] at full credit -> err=1, credit[2]=4.
- grant=0100 while req=0001 -> err=1, no pop, out_valid stays 0.
- With VC_IRU_AGE_URGENT_EN, AGE_MAX=15: hold req ungranted 15 cycles -> urgent=1; grant -> urgent=0 the next cycle.

Source files
------------

// File: rtl/vc_input_request_unit.sv
// Input-port requestor for the wavefront switch allocator: flit FIFO, per-port credits, request FSM.
// Optional build macro VC_IRU_AGE_URGENT_EN adds an age counter and the urgent output.
module vc_input_request_unit #(
    parameter int NUM_PORTS = 4,
    parameter int FLIT_W    = 32,
    parameter int DEPTH     = 4,
    parameter int CREDITS   = 4
`ifdef VC_IRU_AGE_URGENT_EN
    , parameter int AGE_MAX = 15
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FLIT_W-1:0]    in_flit,
    input  logic [NUM_PORTS-1:0] in_dest,
    output logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] grant,
    output logic                 out_valid,
    output logic [FLIT_W-1:0]    out_flit,
    output logic [NUM_PORTS-1:0] out_port,
    input  logic [NUM_PORTS-1:0] credit_return,
`ifdef VC_IRU_AGE_URGENT_EN
    output logic                 urgent,
`endif
    output logic                 err
);

    // state   | meaning
    // IDLE    | FIFO empty, no request
    // REQ     | head valid with credit, requesting head_dest
    // BLOCKED | head valid but no credit on head_dest (or head dest invalid)

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = $clog2(CREDITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        BLOCKED = 2'd2
    } state_t;

    logic [FLIT_W-1:0]    flit_mem [DEPTH];
    logic [NUM_PORTS-1:0] dest_mem [DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic [KW-1:0]        credit [NUM_PORTS];
    logic [NUM_PORTS-1:0] head_dest;
    state_t               state;

    logic                 push;
    logic                 accept;
    logic                 bad_grant;
    logic                 dest_onehot;
    logic [NUM_PORTS-1:0] dest_clean;
    logic [KW-1:0]        credit_nxt [NUM_PORTS];
    logic [NUM_PORTS-1:0] credit_ok_nxt;
    logic                 credit_err;
    logic [CW-1:0]        count_nxt;
    logic [CW-1:0]        count_left;
    logic [PW-1:0]        rd_ptr_nxt;
    logic [NUM_PORTS-1:0] head_dest_nxt;
    state_t               state_nxt;

    // req depends only on registered state, so grant can never loop back into it
    assign req       = (state == REQ) ? head_dest : '0;
    assign in_ready  = (count != CW'(DEPTH));
    assign push      = in_valid & in_ready;
    assign accept    = |(grant & req);
    assign bad_grant = |(grant & ~req);

    assign dest_onehot = (in_dest != '0) &&
                         ((in_dest & (in_dest - NUM_PORTS'(1))) == '0);
    // A malformed destination is stored as zero so it can never raise a request
    assign dest_clean  = dest_onehot ? in_dest : '0;

    always_comb begin
        credit_err = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            credit_nxt[p] = credit[p];
            if (credit_return[p] && !(accept && req[p])) begin
                if (credit[p] == KW'(CREDITS))
                    credit_err = 1'b1;
                else
                    credit_nxt[p] = credit[p] + KW'(1);
            end else if (!credit_return[p] && accept && req[p]) begin
                credit_nxt[p] = credit[p] - KW'(1);
            end
            credit_ok_nxt[p] = (credit_nxt[p] != '0);
        end
    end

    always_comb begin
        count_left = count - CW'(accept);
        count_nxt  = count_left + CW'(push);
        rd_ptr_nxt = rd_ptr + PW'(accept);
        // When the FIFO drains in this cycle, the incoming flit becomes the head
        if (push && (count_left == '0))
            head_dest_nxt = dest_clean;
        else
            head_dest_nxt = dest_mem[rd_ptr_nxt];

        if (count_nxt == '0)
            state_nxt = IDLE;
        else if (|(head_dest_nxt & credit_ok_nxt))
            state_nxt = REQ;
        else
            state_nxt = BLOCKED;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            flit_mem[wr_ptr] <= in_flit;
            dest_mem[wr_ptr] <= dest_clean;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            head_dest <= '0;
            state     <= IDLE;
            out_valid <= 1'b0;
            out_flit  <= '0;
            out_port  <= '0;
            err       <= 1'b0;
            for (int p = 0; p < NUM_PORTS; p++)
                credit[p] <= KW'(CREDITS);
        end else begin
            rd_ptr    <= rd_ptr_nxt;
            wr_ptr    <= wr_ptr + PW'(push);
            count     <= count_nxt;
            head_dest <= head_dest_nxt;
            state     <= state_nxt;
            out_valid <= accept;
            if (accept) begin
                out_flit <= flit_mem[rd_ptr];
                out_port <= head_dest;
            end
            err <= err | bad_grant | credit_err | (push & ~dest_onehot);
            for (int p = 0; p < NUM_PORTS; p++)
                credit[p] <= credit_nxt[p];
        end
    end

`ifdef VC_IRU_AGE_URGENT_EN
    localparam int AW = $clog2(AGE_MAX + 1);

    logic [AW-1:0] age;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            age <= '0;
        end else if ((state == REQ) && !accept) begin
            if (age != AW'(AGE_MAX))
                age <= age + AW'(1);
        end else begin
            age <= '0;
        end
    end

    assign urgent = (age == AW'(AGE_MAX));
`endif

endmodule

// File: tb/tb_vc_input_request_unit.sv
// Directed bench for vc_input_request_unit: FIFO, credits, grant handling, errors, reset.
module tb_vc_input_request_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_flit;
    logic [3:0]  in_dest;
    logic [3:0]  req;
    logic [3:0]  grant;
    logic        out_valid;
    logic [31:0] out_flit;
    logic [3:0]  out_port;
    logic [3:0]  credit_return;
    logic        err;
`ifdef VC_IRU_AGE_URGENT_EN
    logic        urgent;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    vc_input_request_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_flit       (in_flit),
        .in_dest       (in_dest),
        .req           (req),
        .grant         (grant),
        .out_valid     (out_valid),
        .out_flit      (out_flit),
        .out_port      (out_port),
        .credit_return (credit_return),
`ifdef VC_IRU_AGE_URGENT_EN
        .urgent        (urgent),
`endif
        .err           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid      = 1'b0;
        in_flit       = '0;
        in_dest       = '0;
        grant         = '0;
        credit_return = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        check("rst_in_ready", in_ready, 1);
        check("rst_req", req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_flit", out_flit, 0);
        check("rst_out_port", out_port, 0);
        check("rst_err", err, 0);
        reset = 1'b0;
        step();

        // single flit through port 1
        in_valid = 1'b1; in_flit = 32'hA5A5_A5A5; in_dest = 4'b0010;
        step();
        in_valid = 1'b0;
        check("t1_req", req, 4'b0010);
        grant = 4'b0010;
        step();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_flit", out_flit, 32'hA5A5_A5A5);
        check("t1_out_port", out_port, 4'b0010);
        check("t1_req_empty", req, 0);
        check("t1_in_ready", in_ready, 1);
        grant = '0; credit_return = 4'b0010;
        step();
        credit_return = '0;
        check("t1_out_valid_drop", out_valid, 0);
        check("t1_err", err, 0);

        // fill the FIFO on port 2, overflow attempt, then drain in order
        for (int i = 1; i <= 4; i++) begin
            check("t2_ready_before_push", in_ready, 1);
            in_valid = 1'b1; in_flit = 32'h1000_0000 + i; in_dest = 4'b0100;
            step();
        end
        check("t2_full", in_ready, 0);
        check("t2_req", req, 4'b0100);
        in_flit = 32'h1000_0005;
        step();
        check("t2_still_full", in_ready, 0);
        in_valid = 1'b0; grant = 4'b0100;
        step();
        check("t2_out1", out_flit, 32'h1000_0001);
        check("t2_ready_after_pop", in_ready, 1);
        for (int i = 2; i <= 4; i++) begin
            step();
            check("t2_out_valid", out_valid, 1);
            check("t2_out_flit", out_flit, 32'h1000_0000 + i);
        end
        grant = '0;
        step();
        check("t2_no_fifth_valid", out_valid, 0);
        check("t2_no_fifth_req", req, 0);
        credit_return = 4'b0100;
        repeat (4) step();
        credit_return = '0;
        check("t2_err", err, 0);

        // credit exhaustion on port 0, then unblock with one return
        in_valid = 1'b1; in_flit = 32'h2000_0001; in_dest = 4'b0001;
        step();
        check("t3_req", req, 4'b0001);
        grant = 4'b0001;
        for (int i = 2; i <= 5; i++) begin
            in_flit = 32'h2000_0000 + i;
            step();
            check("t3_b2b_valid", out_valid, 1);
            check("t3_b2b_flit", out_flit, 32'h2000_0000 + i - 1);
        end
        in_valid = 1'b0; grant = '0;
        check("t3_blocked_req", req, 0);
        check("t3_blocked_err", err, 0);
        credit_return = 4'b0001;
        step();
        credit_return = '0;
        check("t3_unblock_req", req, 4'b0001);
        check("t3_unblock_ov", out_valid, 0);
        grant = 4'b0001;
        step();
        grant = '0;
        check("t3_fifth_valid", out_valid, 1);
        check("t3_fifth_flit", out_flit, 32'h2000_0005);
        step();
        check("t3_idle_req", req, 0);

        // simultaneous accept and return on port 1 keeps credit at 4
        in_valid = 1'b1; in_flit = 32'h3000_0001; in_dest = 4'b0010;
        step();
        in_valid = 1'b0;
        grant = 4'b0010; credit_return = 4'b0010;
        step();
        check("t4_out_valid", out_valid, 1);
        check("t4_same_cycle_err", err, 0);
        grant = '0;
        step();
        credit_return = '0;
        check("t4_over_return_err", err, 1);

        // asynchronous reset with a flit in flight and one buffered
        in_valid = 1'b1; in_flit = 32'h4000_0001; in_dest = 4'b1000;
        step();
        grant = 4'b1000; in_flit = 32'h4000_0002;
        step();
        check("t6_inflight_valid", out_valid, 1);
        check("t6_inflight_flit", out_flit, 32'h4000_0001);
        check("t6_buffered_req", req, 4'b1000);
        idle_inputs();
        reset = 1'b1;
        #1;
        check("t6_async_out_valid", out_valid, 0);
        check("t6_async_req", req, 0);
        check("t6_async_err", err, 0);
        check("t6_async_out_flit", out_flit, 0);
        check("t6_async_in_ready", in_ready, 1);
        #1;
        reset = 1'b0;
        step();
        check("t6_discarded_req", req, 0);
        check("t6_discarded_ov", out_valid, 0);

        // return at full credit on port 2
        credit_return = 4'b0100;
        step();
        credit_return = '0;
        check("t4_port2_err", err, 1);

        // grant on the wrong port
        do_reset();
        in_valid = 1'b1; in_flit = 32'h5000_0001; in_dest = 4'b0001;
        step();
        in_valid = 1'b0;
        grant = 4'b0100;
        step();
        grant = '0;
        check("t5_err", err, 1);
        check("t5_no_out", out_valid, 0);
        check("t5_no_pop", req, 4'b0001);

        // non-one-hot destination is stored but never requested
        do_reset();
        in_valid = 1'b1; in_flit = 32'h6000_0001; in_dest = 4'b0011;
        step();
        in_valid = 1'b0;
        check("t7_bad_dest_err", err, 1);
        check("t7_bad_dest_req", req, 0);
        step();
        check("t7_bad_dest_req_hold", req, 0);
        check("t7_bad_dest_ready", in_ready, 1);

`ifdef VC_IRU_AGE_URGENT_EN
        do_reset();
        in_valid = 1'b1; in_flit = 32'h7000_0001; in_dest = 4'b0001;
        step();
        in_valid = 1'b0;
        check("t8_urgent_start", urgent, 0);
        repeat (14) step();
        check("t8_urgent_14", urgent, 0);
        step();
        check("t8_urgent_15", urgent, 1);
        grant = 4'b0001;
        step();
        grant = '0;
        check("t8_urgent_clear", urgent, 0);
        check("t8_out_valid", out_valid, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
